// File: rtl/fft_bfly_r2.sv
//============================================================================
// Module   : fft_bfly_r2 (with helper mult_fp)
// Purpose  : Pipelined radix-2 DIT butterfly, y0 = a + b*w, y1 = a - b*w.
//            Three register stages with valid/ready backpressure and a
//            pair counter that flags the last pair of each group.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready, a_re/a_im, b_re/b_im, w_re/w_im (Q2.5)
//            out_valid/out_ready, y0_re/y0_im, y1_re/y1_im (Q6.5), out_last
// Config   : define FFT_BFLY_SCALE_EN to register (a +/- t) >>> 1 in S3.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

// Fixed-point multiplier: floor(a*b / 2^FRAC), truncated to P_W bits.
// P_W is sized so that legal operand ranges never lose significant bits.
module mult_fp #(
    parameter int IN_W = 8,
    parameter int P_W  = 10,
    parameter int FRAC = 5
) (
    input  logic signed [IN_W-1:0] i_a,
    input  logic signed [IN_W-1:0] i_b,
    output logic signed [P_W-1:0]  o_p
);
    logic signed [2*IN_W-1:0] w_full;

    assign w_full = i_a * i_b;
    // Arithmetic shift floors toward minus infinity.
    assign o_p    = P_W'(w_full >>> FRAC);
endmodule

module fft_bfly_r2 #(
    parameter int DATA_W  = 8,
    parameter int FRAC    = 5,
    parameter int N_PAIRS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [DATA_W-1:0] w_re,
    input  logic signed [DATA_W-1:0] w_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W+3:0] y0_re,
    output logic signed [DATA_W+3:0] y0_im,
    output logic signed [DATA_W+3:0] y1_re,
    output logic signed [DATA_W+3:0] y1_im,
    output logic                     out_last
);
    localparam int PROD_W = DATA_W + 2;
    localparam int OUT_W  = DATA_W + 4;
    localparam int c_CNT_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(N_PAIRS - 1);

    // Whole pipeline moves together; it only holds when a valid result
    // is sitting at the output and downstream is not taking it.
    logic w_en;

    logic signed [PROD_W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

    // Stage 1
    logic                     r_v1;
    logic signed [PROD_W-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [DATA_W-1:0] r_a1_re, r_a1_im;
    // Stage 2
    logic                     r_v2;
    logic signed [PROD_W:0]   r_t_re, r_t_im;
    logic signed [DATA_W-1:0] r_a2_re, r_a2_im;
    // Stage 3
    logic                     r_v3;
    logic signed [OUT_W-1:0]  r_y0_re, r_y0_im, r_y1_re, r_y1_im;
    logic [c_CNT_W-1:0]       r_cnt;

    logic signed [OUT_W-1:0]  w_ax_re, w_ax_im, w_tx_re, w_tx_im;
    logic signed [OUT_W-1:0]  w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic signed [OUT_W-1:0]  w_y0_re, w_y0_im, w_y1_re, w_y1_im;

    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;

    mult_fp #(.IN_W(DATA_W), .P_W(PROD_W), .FRAC(FRAC)) u_mul_rr (.i_a(b_re), .i_b(w_re), .o_p(w_p_rr));
    mult_fp #(.IN_W(DATA_W), .P_W(PROD_W), .FRAC(FRAC)) u_mul_ii (.i_a(b_im), .i_b(w_im), .o_p(w_p_ii));
    mult_fp #(.IN_W(DATA_W), .P_W(PROD_W), .FRAC(FRAC)) u_mul_ri (.i_a(b_re), .i_b(w_im), .o_p(w_p_ri));
    mult_fp #(.IN_W(DATA_W), .P_W(PROD_W), .FRAC(FRAC)) u_mul_ir (.i_a(b_im), .i_b(w_re), .o_p(w_p_ir));

    // Sign-extend a and t to the output width before the final add/sub.
    assign w_ax_re = $signed({{(OUT_W-DATA_W){r_a2_re[DATA_W-1]}}, r_a2_re});
    assign w_ax_im = $signed({{(OUT_W-DATA_W){r_a2_im[DATA_W-1]}}, r_a2_im});
    assign w_tx_re = $signed({{(OUT_W-PROD_W-1){r_t_re[PROD_W]}}, r_t_re});
    assign w_tx_im = $signed({{(OUT_W-PROD_W-1){r_t_im[PROD_W]}}, r_t_im});

    assign w_s0_re = w_ax_re + w_tx_re;
    assign w_s0_im = w_ax_im + w_tx_im;
    assign w_s1_re = w_ax_re - w_tx_re;
    assign w_s1_im = w_ax_im - w_tx_im;

`ifdef FFT_BFLY_SCALE_EN
    // Per-stage 1/2 scaling; arithmetic shift floors and keeps the sign.
    assign w_y0_re = w_s0_re >>> 1;
    assign w_y0_im = w_s0_im >>> 1;
    assign w_y1_re = w_s1_re >>> 1;
    assign w_y1_im = w_s1_im >>> 1;
`else
    assign w_y0_re = w_s0_re;
    assign w_y0_im = w_s0_im;
    assign w_y1_re = w_s1_re;
    assign w_y1_im = w_s1_im;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
            r_a1_re <= '0;
            r_a1_im <= '0;
            r_t_re  <= '0;
            r_t_im  <= '0;
            r_a2_re <= '0;
            r_a2_im <= '0;
            r_y0_re <= '0;
            r_y0_im <= '0;
            r_y1_re <= '0;
            r_y1_im <= '0;
        end else if (w_en) begin
            // Data registers load unconditionally on advance; bubbles carry
            // don't-care data that out_valid masks.
            r_v1    <= in_valid;
            r_p_rr  <= w_p_rr;
            r_p_ii  <= w_p_ii;
            r_p_ri  <= w_p_ri;
            r_p_ir  <= w_p_ir;
            r_a1_re <= a_re;
            r_a1_im <= a_im;

            r_v2    <= r_v1;
            r_t_re  <= {r_p_rr[PROD_W-1], r_p_rr} - {r_p_ii[PROD_W-1], r_p_ii};
            r_t_im  <= {r_p_ri[PROD_W-1], r_p_ri} + {r_p_ir[PROD_W-1], r_p_ir};
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;

            r_v3    <= r_v2;
            r_y0_re <= w_y0_re;
            r_y0_im <= w_y0_im;
            r_y1_re <= w_y1_re;
            r_y1_im <= w_y1_im;
        end
    end

    // Counts output handshakes; wraps at N_PAIRS-1 (stays 0 for N_PAIRS=1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_v3 && out_ready) begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_last  = r_v3 && (r_cnt == c_CNT_MAX);
    assign y0_re     = r_y0_re;
    assign y0_im     = r_y0_im;
    assign y1_re     = r_y1_re;
    assign y1_im     = r_y1_im;

endmodule

`default_nettype wire

// File: tb/tb_fft_bfly_r2.sv
//============================================================================
// Module   : tb_fft_bfly_r2
// Purpose  : Self-checking bench for fft_bfly_r2. Expected results come from
//            an integer reference model of the butterfly arithmetic and a
//            queue-based scoreboard for ordering, latency and grouping.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fft_bfly_r2;
    localparam int DATA_W  = 8;
    localparam int FRAC    = 5;
    localparam int N_PAIRS = 4;
    localparam int OUT_W   = DATA_W + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     in_valid, in_ready, out_valid, out_ready, out_last;
    logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [OUT_W-1:0]  y0_re, y0_im, y1_re, y1_im;

    fft_bfly_r2 #(.DATA_W(DATA_W), .FRAC(FRAC), .N_PAIRS(N_PAIRS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .out_last(out_last)
    );

    typedef struct {
        int y0r, y0i, y1r, y1i;
        int acc;
        bit stalled;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncall  = 0;
    int   hs     = 0;
    bit   prev_stall = 1'b0;
    logic signed [OUT_W-1:0] h_y0r, h_y0i, h_y1r, h_y1i;
    logic h_last;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Mathematical floor division for a positive divisor.
    function automatic int fdiv(input int x, input int d);
        int qv;
        qv = x / d;
        if ((x % d) != 0 && x < 0) qv = qv - 1;
        return qv;
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int br,
                                   input int bi, input int wr, input int wi);
        exp_t e;
        int sc, tre, tim;
        sc  = 1 << FRAC;
        tre = fdiv(br * wr, sc) - fdiv(bi * wi, sc);
        tim = fdiv(br * wi, sc) + fdiv(bi * wr, sc);
`ifdef FFT_BFLY_SCALE_EN
        e.y0r = fdiv(ar + tre, 2);
        e.y0i = fdiv(ai + tim, 2);
        e.y1r = fdiv(ar - tre, 2);
        e.y1i = fdiv(ai - tim, 2);
`else
        e.y0r = ar + tre;
        e.y0i = ai + tim;
        e.y1r = ar - tre;
        e.y1i = ai - tim;
`endif
        e.acc = 0;
        e.stalled = 1'b0;
        return e;
    endfunction

    // One clock: drive inputs, observe at the falling edge, score, advance.
    task automatic cycle(input bit iv, input bit ordy, input int ar, input int ai,
                         input int br, input int bi, input int wr, input int wi,
                         output bit accepted);
        exp_t e;
        bit stall;
        in_valid  = iv;
        out_ready = ordy;
        a_re = ar[DATA_W-1:0];
        a_im = ai[DATA_W-1:0];
        b_re = br[DATA_W-1:0];
        b_im = bi[DATA_W-1:0];
        w_re = wr[DATA_W-1:0];
        w_im = wi[DATA_W-1:0];
        @(negedge clk);
        ncall++;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_y0_re", y0_re, h_y0r);
            chk("hold_y0_im", y0_im, h_y0i);
            chk("hold_y1_re", y1_re, h_y1r);
            chk("hold_y1_im", y1_im, h_y1i);
            chk("hold_last", out_last, h_last);
        end
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (q.size() == 0)
            chk("no_spurious_out", out_valid, 0);
        else if (!q[0].stalled)
            chk("out_valid_timing", out_valid, (ncall - q[0].acc) >= 3);
        if (!out_valid)
            chk("last_without_valid", out_last, 0);
        stall = out_valid && !out_ready;
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("y0_re", y0_re, e.y0r);
            chk("y0_im", y0_im, e.y0i);
            chk("y1_re", y1_re, e.y1r);
            chk("y1_im", y1_im, e.y1i);
            chk("out_last", out_last, (hs % N_PAIRS) == (N_PAIRS - 1));
            if (!e.stalled) chk("latency", ncall - e.acc, 3);
            hs++;
        end
        if (stall)
            for (int i = 0; i < q.size(); i++) q[i].stalled = 1'b1;
        accepted = iv && in_ready;
        if (accepted) begin
            e = model(ar, ai, br, bi, wr, wi);
            e.acc = ncall;
            q.push_back(e);
        end
        prev_stall = stall;
        h_y0r = y0_re; h_y0i = y0_im; h_y1r = y1_re; h_y1i = y1_im;
        h_last = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic rcycle(input bit iv, input bit ordy, output bit accepted);
        int ar, ai, br, bi, wr, wi;
        ar = int'($urandom_range(255)) - 128;
        ai = int'($urandom_range(255)) - 128;
        br = int'($urandom_range(255)) - 128;
        bi = int'($urandom_range(255)) - 128;
        wr = int'($urandom_range(64)) - 32;
        wi = int'($urandom_range(64)) - 32;
        cycle(iv, ordy, ar, ai, br, bi, wr, wi, accepted);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;   // handshake at the reset edge must be ignored
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        q.delete();
        hs = 0;
        prev_stall = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_y0_re", y0_re, 0);
        chk("rst_y0_im", y0_im, 0);
        chk("rst_y1_re", y1_re, 0);
        chk("rst_y1_im", y1_im, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 30 && q.size() > 0; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, acc);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int got;
        int pat[4] = '{1, 0, 0, 1};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Identity twiddle, -j twiddle and negative extremes, one at a time.
        cycle(1, 1, 32, 0, 32, 0, 32, 0, acc);
        chk("accept_identity", acc, 1);
        drain();
        cycle(1, 1, 32, 0, 32, 0, 0, -32, acc);
        drain();
        cycle(1, 1, -128, -128, -128, 0, -32, 0, acc);
        drain();

        // Back-to-back random pairs at full throughput.
        for (int i = 0; i < 12; i++) rcycle(1, 1, acc);
        drain();

        // Backpressure: 8 pairs with out_ready pattern 1,0,0,1,...
        got = 0;
        for (int i = 0; i < 100 && got < 8; i++) begin
            rcycle(1, pat[i % 4][0], acc);
            if (acc) got++;
        end
        chk("bp_accepted", got, 8);
        for (int i = 0; i < 40 && q.size() > 0; i++) rcycle(0, pat[i % 4][0], acc);
        chk("bp_drained", q.size(), 0);
        drain();

        // Grouping from a fresh counter: 10 back-to-back pairs.
        do_reset();
        for (int i = 0; i < 10; i++) rcycle(1, 1, acc);
        drain();
        chk("group_hs", hs, 10);

        // Reset with three pairs in flight; nothing stale may emerge.
        for (int i = 0; i < 3; i++) rcycle(1, 1, acc);
        do_reset();
        for (int i = 0; i < 5; i++) rcycle(0, 1, acc);
        rcycle(1, 1, acc);
        chk("post_reset_accept", acc, 1);
        drain();

        // Random valid/ready mix.
        for (int i = 0; i < 60; i++) rcycle($urandom_range(1), $urandom_range(1), acc);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
